// File: rtl/median_select_ctrl.sv
// Quickselect sequencer for the median filter partition datapath: one median per window.
// Optional iteration counter output enabled by defining MEDIAN_SELECT_ITER_CNT_EN.
module median_select_ctrl #(
  parameter int         BUFF_SIZE     = 32,
  parameter int         BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter logic [7:0] INIT_PIVOT    = 8'd128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BUFF_SIZE_BIT-1:0] win_size,
  output logic                     busy,
  output logic [7:0]               pivot,
  output logic [BUFF_SIZE_BIT-1:0] buff_size,
  input  logic                     fill_done,
  input  logic [BUFF_SIZE_BIT-1:0] lower_size,
  input  logic [BUFF_SIZE_BIT-1:0] equal_size,
  input  logic [BUFF_SIZE_BIT-1:0] larger_size,
  input  logic [7:0]               min_lower,
  input  logic [7:0]               max_lower,
  input  logic [7:0]               min_larger,
  input  logic [7:0]               max_larger,
  output logic                     send_req,
  output logic                     sending,
  output logic                     recirc_sel,
  input  logic                     send_done,
  output logic [7:0]               median,
  output logic                     median_valid,
`ifdef MEDIAN_SELECT_ITER_CNT_EN
  output logic [3:0]               iter_count,
`endif
  input  logic                     median_ready
);

  localparam int BW = BUFF_SIZE_BIT;
  localparam logic [BW-1:0] ZERO_W = {BW{1'b0}};
  localparam logic [BW-1:0] ONE_W  = {{(BW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, FILL, DECIDE, SEND, DONE} state_t;

  state_t          state_r, state_s;
  logic [BW-1:0]   buff_size_r, buff_size_s, k_r, k_s;
  logic [BW-1:0]   l_r, l_s, e_r, e_s, g_r, g_s;
  logic [7:0]      pivot_r, pivot_s, lpivot_r, lpivot_s, median_r, median_s;
  logic [7:0]      min_l_r, min_l_s, max_l_r, max_l_s, min_g_r, min_g_s, max_g_r, max_g_s;
  logic            recirc_sel_r, recirc_sel_s;
  logic            busy_r, sending_r, send_req_r, median_valid_r;
  logic [8:0]      sum_lower_s, sum_larger_s;
  logic [3:0]      iter_r, iter_s;

  assign sum_lower_s  = {1'b0, min_l_r} + {1'b0, max_l_r};
  assign sum_larger_s = {1'b0, min_g_r} + {1'b0, max_g_r};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next datapath-register values
  always_comb begin
    state_s      = state_r;
    buff_size_s  = buff_size_r;
    k_s          = k_r;
    pivot_s      = pivot_r;
    lpivot_s     = lpivot_r;
    median_s     = median_r;
    recirc_sel_s = recirc_sel_r;
    l_s          = l_r;
    e_s          = e_r;
    g_s          = g_r;
    min_l_s      = min_l_r;
    max_l_s      = max_l_r;
    min_g_s      = min_g_r;
    max_g_s      = max_g_r;
    iter_s       = iter_r;
    case (state_r)
      IDLE: begin
        if (start && (win_size != ZERO_W)) begin
          buff_size_s = win_size;
          k_s         = (win_size - ONE_W) >> 1;
          pivot_s     = INIT_PIVOT;
          iter_s      = 4'd0;
          state_s     = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (fill_done) begin
          l_s      = lower_size;
          e_s      = equal_size;
          g_s      = larger_size;
          min_l_s  = min_lower;
          max_l_s  = max_lower;
          min_g_s  = min_larger;
          max_g_s  = max_larger;
          lpivot_s = pivot_r;
          iter_s   = (iter_r == 4'd15) ? 4'd15 : iter_r + 4'd1;
          state_s  = DECIDE;
        end else begin
          state_s = FILL;
        end
      end
      DECIDE: begin
        if (k_r < l_r) begin
          if (min_l_r == max_l_r) begin
            median_s = min_l_r;
            state_s  = DONE;
          end else begin
            buff_size_s  = l_r;
            pivot_s      = 8'(sum_lower_s >> 1);
            recirc_sel_s = 1'b0;
            state_s      = SEND;
          end
        end else if (k_r < (l_r + e_r)) begin
          median_s = lpivot_r;
          state_s  = DONE;
        end else begin
          k_s = k_r - l_r - e_r;
          if (min_g_r == max_g_r) begin
            median_s = min_g_r;
            state_s  = DONE;
          end else begin
            buff_size_s  = g_r;
            pivot_s      = 8'(sum_larger_s >> 1);
            recirc_sel_s = 1'b1;
            state_s      = SEND;
          end
        end
      end
      SEND: begin
        if (send_done) begin
          state_s = FILL;
        end else begin
          state_s = SEND;
        end
      end
      DONE: begin
        if (median_valid_r && median_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath registers and registered status outputs, derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      buff_size_r    <= ZERO_W;
      k_r            <= ZERO_W;
      l_r            <= ZERO_W;
      e_r            <= ZERO_W;
      g_r            <= ZERO_W;
      pivot_r        <= INIT_PIVOT;
      lpivot_r       <= 8'd0;
      median_r       <= 8'd0;
      min_l_r        <= 8'd0;
      max_l_r        <= 8'd0;
      min_g_r        <= 8'd0;
      max_g_r        <= 8'd0;
      recirc_sel_r   <= 1'b0;
      iter_r         <= 4'd0;
      busy_r         <= 1'b0;
      sending_r      <= 1'b0;
      send_req_r     <= 1'b0;
      median_valid_r <= 1'b0;
    end else begin
      buff_size_r    <= buff_size_s;
      k_r            <= k_s;
      l_r            <= l_s;
      e_r            <= e_s;
      g_r            <= g_s;
      pivot_r        <= pivot_s;
      lpivot_r       <= lpivot_s;
      median_r       <= median_s;
      min_l_r        <= min_l_s;
      max_l_r        <= max_l_s;
      min_g_r        <= min_g_s;
      max_g_r        <= max_g_s;
      recirc_sel_r   <= recirc_sel_s;
      iter_r         <= iter_s;
      busy_r         <= (state_s != IDLE);
      sending_r      <= (state_s == SEND);
      send_req_r     <= (state_s == SEND) && (state_r != SEND);
      median_valid_r <= (state_s == DONE);
    end
  end

  assign busy         = busy_r;
  assign pivot        = pivot_r;
  assign buff_size    = buff_size_r;
  assign send_req     = send_req_r;
  assign sending      = sending_r;
  assign recirc_sel   = recirc_sel_r;
  assign median       = median_r;
  assign median_valid = median_valid_r;
`ifdef MEDIAN_SELECT_ITER_CNT_EN
  assign iter_count   = iter_r;
`endif

endmodule

// File: tb/tb_median_select_ctrl.sv
// Bench for median_select_ctrl: acts as the partition datapath and checks medians against sorting.
module tb_median_select_ctrl;
  localparam int BW = 6;

  typedef struct {
    int               n;
    logic [31:0][7:0] pix;
    int               exp_med;
    int               exp_passes;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start, fill_done, send_done, median_ready;
  logic [BW-1:0] win_size, lower_size, equal_size, larger_size;
  logic [7:0]    min_lower, max_lower, min_larger, max_larger;
  logic          busy, send_req, sending, recirc_sel, median_valid;
  logic [7:0]    pivot, median;
  logic [BW-1:0] buff_size;
`ifdef MEDIAN_SELECT_ITER_CNT_EN
  logic [3:0]    iter_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  median_select_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .win_size(win_size), .busy(busy),
    .pivot(pivot), .buff_size(buff_size), .fill_done(fill_done),
    .lower_size(lower_size), .equal_size(equal_size), .larger_size(larger_size),
    .min_lower(min_lower), .max_lower(max_lower), .min_larger(min_larger),
    .max_larger(max_larger), .send_req(send_req), .sending(sending),
    .recirc_sel(recirc_sel), .send_done(send_done), .median(median),
    .median_valid(median_valid),
`ifdef MEDIAN_SELECT_ITER_CNT_EN
    .iter_count(iter_count),
`endif
    .median_ready(median_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] qmin(input logic [7:0] q[$]);
    logic [7:0] m = 8'd255;
    if (q.size() == 0) return 8'd0;
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  function automatic logic [7:0] qmax(input logic [7:0] q[$]);
    logic [7:0] m = 8'd0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  // Drives one window through the DUT, playing the fill/partition stage
  task automatic run_window(input vec_t v, input int rdy_delay, input bit poke);
    logic [7:0] cur[$], lo[$], hi[$], srt[$];
    logic [7:0] exp_piv, exp_med, med_hold;
    logic [8:0] sum;
    int k, eq, passes;
    bit done, exp_done, nsel;
    for (int i = 0; i < v.n; i++) cur.push_back(v.pix[i]);
    srt = cur;
    srt.sort();
    exp_med = (v.exp_med >= 0) ? v.exp_med[7:0] : srt[(v.n - 1) >> 1];
    k = (v.n - 1) >> 1;
    exp_piv = 8'd128;
    passes = 0;
    done = 1'b0;
    nsel = 1'b0;
    start = 1'b1;
    win_size = v.n[BW-1:0];
    step();
    start = 1'b0;
    while (!done && passes < 12) begin
      chk("busy_fill", busy, 1);
      chk("buff_size", buff_size, cur.size());
      chk("pivot", pivot, exp_piv);
      if (poke && passes == 0) begin
        start = 1'b1;
        win_size = 6'd3;
        send_done = 1'b1;
        step();
        start = 1'b0;
        send_done = 1'b0;
        chk("busy_poke", busy, 1);
        chk("buff_size_poke", buff_size, cur.size());
        chk("send_req_poke", send_req, 0);
      end
      lo.delete();
      hi.delete();
      eq = 0;
      foreach (cur[i]) begin
        if (cur[i] < exp_piv) lo.push_back(cur[i]);
        else if (cur[i] == exp_piv) eq++;
        else hi.push_back(cur[i]);
      end
      lower_size  = BW'(lo.size());
      equal_size  = BW'(eq);
      larger_size = BW'(hi.size());
      min_lower   = qmin(lo);
      max_lower   = qmax(lo);
      min_larger  = qmin(hi);
      max_larger  = qmax(hi);
      fill_done   = 1'b1;
      step();
      fill_done   = 1'b0;
      passes++;
      step();
      if (k < lo.size()) begin
        exp_done = (qmin(lo) == qmax(lo));
        nsel = 1'b0;
      end else if (k < lo.size() + eq) begin
        exp_done = 1'b1;
      end else begin
        k -= lo.size() + eq;
        exp_done = (qmin(hi) == qmax(hi));
        nsel = 1'b1;
      end
      chk("median_valid_decide", median_valid, exp_done);
      if (median_valid) begin
        done = 1'b1;
      end else begin
        chk("send_req", send_req, 1);
        chk("sending", sending, 1);
        chk("recirc_sel", recirc_sel, nsel);
        cur = nsel ? hi : lo;
        sum = {1'b0, qmin(cur)} + {1'b0, qmax(cur)};
        exp_piv = sum[8:1];
        repeat ($urandom_range(0, 2)) begin
          step();
          chk("send_req_pulse", send_req, 0);
          chk("sending_hold", sending, 1);
        end
        send_done = 1'b1;
        step();
        send_done = 1'b0;
      end
    end
    if (!done) begin
      chk("pass_timeout", 0, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
    end else begin
      chk("median", median, exp_med);
      med_hold = median;
      repeat (rdy_delay) begin
        step();
        chk("valid_stall", median_valid, 1);
        chk("median_stall", median, med_hold);
      end
`ifdef MEDIAN_SELECT_ITER_CNT_EN
      chk("iter_count", iter_count, passes);
`endif
      median_ready = 1'b1;
      step();
      median_ready = 1'b0;
      chk("valid_drop", median_valid, 0);
      chk("busy_idle", busy, 0);
      chk("median_hold", median, med_hold);
      if (v.exp_passes >= 0) chk("passes", passes, v.exp_passes);
      chk("pass_bound", passes <= 9, 1);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int base;
    rst = 1'b1; start = 1'b0; fill_done = 1'b0; send_done = 1'b0; median_ready = 1'b0;
    win_size = '0; lower_size = '0; equal_size = '0; larger_size = '0;
    min_lower = 8'd0; max_lower = 8'd0; min_larger = 8'd0; max_larger = 8'd0;

    v.pix = '0;
    v.n = 9; for (int i = 0; i < 9; i++) v.pix[i] = 8'((i + 1) * 10);
    v.exp_med = 50; v.exp_passes = 2; tbl.push_back(v);
    v.pix = '0; v.n = 5; for (int i = 0; i < 5; i++) v.pix[i] = 8'd7;
    v.exp_med = 7; v.exp_passes = 1; tbl.push_back(v);
    v.pix = '0; v.n = 1; v.pix[0] = 8'd200; v.exp_med = 200; v.exp_passes = 1; tbl.push_back(v);
    v.pix = '0; v.n = 1; v.pix[0] = 8'd128; v.exp_med = 128; v.exp_passes = 1; tbl.push_back(v);
    for (int r = 0; r < 15; r++) begin
      v.pix = '0;
      v.n = $urandom_range(1, 32);
      base = $urandom_range(0, 250);
      for (int i = 0; i < v.n; i++) begin
        case (r % 3)
          0: v.pix[i] = 8'($urandom_range(0, 255));
          1: v.pix[i] = 8'(base + $urandom_range(0, 3));
          default: v.pix[i] = (i % 2 == 0) ? 8'd128 : 8'($urandom_range(0, 255));
        endcase
      end
      v.exp_med = -1; v.exp_passes = -1; tbl.push_back(v);
    end

    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_pivot", pivot, 128);
    chk("rst_buff_size", buff_size, 0);
    chk("rst_median", median, 0);
    chk("rst_median_valid", median_valid, 0);
    chk("rst_send_req", send_req, 0);
    chk("rst_sending", sending, 0);
    chk("rst_recirc_sel", recirc_sel, 0);

    start = 1'b1; win_size = 6'd0;
    step();
    start = 1'b0;
    chk("zero_win_busy", busy, 0);
    step();
    chk("zero_win_busy2", busy, 0);

    // Reset while a recirculation is in flight
    start = 1'b1; win_size = 6'd9;
    step();
    start = 1'b0;
    lower_size = 6'd9; equal_size = 6'd0; larger_size = 6'd0;
    min_lower = 8'd10; max_lower = 8'd90; min_larger = 8'd0; max_larger = 8'd0;
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    step();
    chk("pre_rst_sending", sending, 1);
    chk("pre_rst_pivot", pivot, 50);
    chk("pre_rst_buff_size", buff_size, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("send_rst_sending", sending, 0);
    chk("send_rst_send_req", send_req, 0);
    chk("send_rst_pivot", pivot, 128);
    chk("send_rst_busy", busy, 0);

    foreach (tbl[i]) run_window(tbl[i], (i == 0) ? 5 : $urandom_range(0, 2), i == 1 || i == 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/median_select_ctrl.md
Name: median_select_ctrl

Overview:
- Iterative quickselect sequencer for the median filter's partition datapath.
- Per window: drives pivot, buffer size and the median rank into the fill/partition stage.
- After each pass, latches the partition sizes and the min/max of each partition and decides to stop or recirculate the lower or larger partition with a new pivot.
- Emits one median per window through a valid/ready output.

Parameters:
- BUFF_SIZE, 32, maximum window size in pixels
- BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of size and rank fields
- INIT_PIVOT, 8'd128, pivot used on the first pass of every window

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin new window; accepted only in IDLE
- win_size  in  BUFF_SIZE_BIT  pixel count of window; sampled with start
- busy  out  1  high in every state except IDLE
- pivot  out  8  pivot to partition stage
- buff_size  out  BUFF_SIZE_BIT  pixels expected this pass
- fill_done  in  1  pass complete
- lower_size, equal_size, larger_size  in  BUFF_SIZE_BIT each  partition counts
- min_lower, max_lower, min_larger, max_larger  in  8 each  partition extremes
- send_req  out  1  recirculation request; clears partition counters and extremes
- sending  out  1  recirculation in progress
- recirc_sel  out  1  0 = recirculate lower partition, 1 = recirculate larger partition
- send_done  in  1  recirculation finished
- median  out  8  result
- median_valid  out  1  result valid
- median_ready  in  1  consumer accepts result

Behaviour:
- Reset values: state IDLE; all outputs 0 except pivot = INIT_PIVOT.
- IDLE:
  - On start with win_size != 0: buff_size <= win_size; k <= (win_size-1)>>1 (lower median); pivot <= INIT_PIVOT; go to FILL.
  - start with win_size == 0 is ignored; busy stays 0.
- FILL: wait for fill_done. On that edge, latch L, E, G, the four extremes and the current pivot into internal registers, then go to DECIDE.
- DECIDE (one cycle, combinational on the latched values):
  - k < L:
    - If min_lower == max_lower: median <= min_lower; go to DONE.
    - Otherwise: buff_size <= L; pivot <= (min_lower+max_lower)>>1 using a 9-bit sum; recirc_sel <= 0; go to SEND.
  - L <= k < L+E: median <= latched pivot; go to DONE.
  - Otherwise: k <= k-L-E.
    - If min_larger == max_larger: median <= min_larger; go to DONE.
    - Otherwise: buff_size <= G; pivot <= midpoint of the larger extremes; recirc_sel <= 1; go to SEND.
- SEND:
  - send_req is a single-cycle pulse on entry.
  - sending is high for the whole state.
  - On send_done go to FILL.
  - send_done arriving in the entry cycle is honoured.
- DONE:
  - median_valid high; median is stable until the handshake.
  - On median_valid & median_ready go to IDLE.
  - median_valid drops the next cycle; median holds its value.
- Arithmetic: all rank and size math is unsigned BUFF_SIZE_BIT wide. L+E+G == buff_size is guaranteed by the datapath and is not checked.
- The midpoint pivot satisfies min <= pivot < max, so every recirculated pass strictly shrinks the partition. Termination takes at most 9 passes for 8-bit data.
- Input handling:
  - fill_done outside FILL is ignored.
  - send_done outside SEND is ignored.
  - start outside IDLE is ignored.
- rst in any state returns to IDLE next edge with reset values; any pending recirculation is abandoned.

Optional Feature:
- Macro: MEDIAN_SELECT_ITER_CNT_EN.
- When defined:
  - Adds output iter_count [3:0].
  - Cleared on accepted start; increments on each FILL->DECIDE transition, saturating at 15.
  - Valid and stable while median_valid is high.
- When undefined: port absent, no counter logic.

Test Plan:
- Window of 9 pixels {10,20,...,90}, INIT_PIVOT 128:
  - Pass 1: L=9, min 10, max 90 -> SEND with recirc_sel=0, buff_size=9, pivot=50.
  - Pass 2: L=4, E=1, G=4 -> median=50, iter_count=2.
- 5 pixels all equal to 7 -> pass 1 gives L=5, min=max=7 -> median=7 with no SEND; iter_count=1.
- Single pixels:
  - win_size=1, pixel 200 -> G=1, k becomes 0, min=max=200 -> median=200.
  - win_size=1, pixel 128 -> E=1 -> median=128.
- win_size=0 with start -> busy stays 0. start pulsed during FILL -> ignored; buff_size and k unchanged.
- median_ready held low for 5 cycles in DONE -> median_valid and median stable. Ready high -> IDLE next cycle; a new start is accepted.
- rst asserted in SEND with sending=1 -> next cycle IDLE, sending=0, send_req=0, pivot=128, busy=0.
